// File: rtl/celery_pkg.sv
// rtl/celery_pkg.sv - shared pipeline types and pixel writer helpers
package celery_pkg;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] x;
        logic [15:0] y;
    } fragment_t;

    typedef enum logic [1:0] {
        PW_IDLE,
        PW_DRAIN,
        PW_CLEAR
    } pw_state_t;

    // Widen the {R,G,B} channel enables to a per-bit RGB565 mask.
    function automatic logic [15:0] rgb_mask_expand(input logic [2:0] mask);
        return {{5{mask[2]}}, {6{mask[1]}}, {5{mask[0]}}};
    endfunction

endpackage

// File: rtl/pixel_writer_if.sv
// rtl/pixel_writer_if.sv - fragment/color stream into the pixel writer
interface pixel_writer_if;
    import celery_pkg::*;

    fragment_t frag_in;
    rgb565_t   color_in;
    logic      frag_in_valid;
    logic      frag_in_ready;

    modport master (
        output frag_in,
        output color_in,
        output frag_in_valid,
        input  frag_in_ready
    );

    modport slave (
        input  frag_in,
        input  color_in,
        input  frag_in_valid,
        output frag_in_ready
    );
endinterface

// File: rtl/fb_ram_1w2r.sv
// rtl/fb_ram_1w2r.sv - one write port, two registered read-first read ports
module fb_ram_1w2r #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             a_en,
    input  logic [AW-1:0]    a_addr,
    output logic [WIDTH-1:0] a_data,
    input  logic             b_en,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered reads see the pre-write contents of a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_en) begin
                a_data <= mem[a_addr];
            end
            if (b_en) begin
                b_data <= mem[b_addr];
            end
        end
    end
endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - masked RMW color writer with clear engine and scanout
module pixel_writer
    import celery_pkg::*;
#(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    localparam int SIZE     = FB_WIDTH * FB_HEIGHT,
    localparam int AW       = $clog2(SIZE)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           color_write_enable,
    input  logic [2:0]     rgb_mask,
    input  logic           fb_clear,
    input  logic [15:0]    fb_clear_color,
    output logic           fb_clearing,
    pixel_writer_if.slave  frag,
    input  logic           scan_rd_en,
    input  logic [AW-1:0]  scan_rd_addr,
    output logic [15:0]    scan_rd_data,
    output logic [31:0]    pix_written,
    output logic [31:0]    pix_dropped
);
    pw_state_t     state, next_state;
    logic          ready;
    logic [AW-1:0] addr_in;
    logic          in_bounds, accept, write_ok, load;

    logic          s1_write, s1_fwd;
    logic [AW-1:0] s1_addr;
    logic [15:0]   s1_color, s1_mask, s1_fwd_data;
    logic [15:0]   rmw_data, old_pixel, merged;

    logic [AW-1:0] clr_addr;
    logic [15:0]   clear_color;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    // Bounds are judged on the full-width coordinates so large x/y never alias.
    assign in_bounds = (frag.frag_in.x < 16'(FB_WIDTH)) && (frag.frag_in.y < 16'(FB_HEIGHT));
    assign addr_in   = AW'(frag.frag_in.y) * AW'(FB_WIDTH) + AW'(frag.frag_in.x);
    assign accept    = frag.frag_in_valid && ready;
    assign write_ok  = frag.frag_in.valid && in_bounds && color_write_enable;
    assign load      = accept && write_ok;

    assign frag.frag_in_ready = ready;

    // Back-to-back writes to one pixel take the old value from the previous merge.
    assign old_pixel = s1_fwd ? s1_fwd_data : rmw_data;
    assign merged    = (s1_color & s1_mask) | (old_pixel & ~s1_mask);

    // S1 pipeline register; the old pixel is fetched during the acceptance cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_write    <= 1'b0;
            s1_fwd      <= 1'b0;
            s1_addr     <= '0;
            s1_color    <= '0;
            s1_mask     <= '0;
            s1_fwd_data <= '0;
        end else begin
            s1_write <= load;
            if (load) begin
                s1_addr     <= addr_in;
                s1_color    <= frag.color_in;
                s1_mask     <= rgb_mask_expand(rgb_mask);
                s1_fwd      <= s1_write && (s1_addr == addr_in);
                s1_fwd_data <= merged;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PW_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, handshake and memory write-port steering.
    always_comb begin
        next_state  = state;
        ready       = 1'b0;
        fb_clearing = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = s1_addr;
        mem_wdata   = merged;
        case (state)
            PW_IDLE: begin
                ready  = 1'b1;
                mem_we = s1_write;
                if (fb_clear) begin
                    next_state = PW_DRAIN;
                end
            end
            PW_DRAIN: begin
                // S1 cannot reload here, so it is empty after this one cycle.
                fb_clearing = 1'b1;
                mem_we      = s1_write;
                next_state  = PW_CLEAR;
            end
            PW_CLEAR: begin
                fb_clearing = 1'b1;
                mem_we      = 1'b1;
                mem_waddr   = clr_addr;
                mem_wdata   = clear_color;
                if (clr_addr == AW'(SIZE - 1)) begin
                    next_state = PW_IDLE;
                end
            end
            default: next_state = PW_IDLE;
        endcase
    end

    // Clear engine: latch the fill color on start, walk addresses while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_color <= '0;
            clr_addr    <= '0;
        end else begin
            if (state == PW_IDLE && fb_clear) begin
                clear_color <= fb_clear_color;
            end
            clr_addr <= (state == PW_CLEAR) ? clr_addr + 1'b1 : '0;
        end
    end

    // Counters; a clear start zeroes them and also absorbs the fragment
    // accepted alongside it, whose write lands in the drain cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_written <= '0;
            pix_dropped <= '0;
        end else if (state == PW_IDLE && fb_clear) begin
            pix_written <= '0;
            pix_dropped <= '0;
        end else begin
            if (accept && !write_ok) begin
                pix_dropped <= pix_dropped + 1'b1;
            end
            if (s1_write && state == PW_IDLE) begin
                pix_written <= pix_written + 1'b1;
            end
        end
    end

    fb_ram_1w2r #(
        .DEPTH (SIZE),
        .WIDTH (16),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .a_en   (load),
        .a_addr (addr_in),
        .a_data (rmw_data),
        .b_en   (scan_rd_en),
        .b_addr (scan_rd_addr),
        .b_data (scan_rd_data)
    );
endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - randomized bench for pixel_writer against a framebuffer model
module tb_pixel_writer;
    import celery_pkg::*;

    localparam int W    = 16;
    localparam int H    = 8;
    localparam int SIZE = W * H;
    localparam int AW   = $clog2(SIZE);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          color_write_enable = 1'b0;
    logic [2:0]    rgb_mask = 3'b000;
    logic          fb_clear = 1'b0;
    logic [15:0]   fb_clear_color = 16'h0000;
    logic          fb_clearing;
    logic          scan_rd_en = 1'b0;
    logic [AW-1:0] scan_rd_addr = '0;
    logic [15:0]   scan_rd_data;
    logic [31:0]   pix_written;
    logic [31:0]   pix_dropped;

    pixel_writer_if fif();

    always #5 clk = ~clk;

    pixel_writer #(
        .FB_WIDTH  (W),
        .FB_HEIGHT (H)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .color_write_enable (color_write_enable),
        .rgb_mask           (rgb_mask),
        .fb_clear           (fb_clear),
        .fb_clear_color     (fb_clear_color),
        .fb_clearing        (fb_clearing),
        .frag               (fif),
        .scan_rd_en         (scan_rd_en),
        .scan_rd_addr       (scan_rd_addr),
        .scan_rd_data       (scan_rd_data),
        .pix_written        (pix_written),
        .pix_dropped        (pix_dropped)
    );

    logic [15:0] mem_m [SIZE];
    logic [31:0] wr_m = 0;
    logic [31:0] dr_m = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a fragment for the next edge and apply its effect to the model.
    task automatic drive_frag(input logic [15:0] x, input logic [15:0] y, input logic v,
                              input logic [15:0] col, input logic [2:0] m, input logic cwe);
        logic [15:0] old;
        int          idx;
        fif.frag_in.x      = x;
        fif.frag_in.y      = y;
        fif.frag_in.valid  = v;
        fif.color_in       = rgb565_t'(col);
        fif.frag_in_valid  = 1'b1;
        rgb_mask           = m;
        color_write_enable = cwe;
        if (v && (int'(x) < W) && (int'(y) < H) && cwe) begin
            idx        = int'(y) * W + int'(x);
            old        = mem_m[idx];
            mem_m[idx] = {m[2] ? col[15:11] : old[15:11],
                          m[1] ? col[10:5]  : old[10:5],
                          m[0] ? col[4:0]   : old[4:0]};
            wr_m++;
        end else begin
            dr_m++;
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic v,
                        input logic [15:0] col, input logic [2:0] m, input logic cwe);
        drive_frag(x, y, v, col, m, cwe);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fif.frag_in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_coords(output logic [15:0] x, output logic [15:0] y);
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) begin
            x = 16'h8000 | 16'($urandom_range(0, W - 1));
            y = 16'($urandom_range(0, H - 1));
        end else if (r < 5) begin
            x = 16'($urandom_range(0, 1));
            y = 16'h0000;
        end else begin
            x = 16'($urandom_range(0, W + 1));
            y = 16'($urandom_range(0, H));
        end
    endtask

    task automatic rand_send();
        logic [15:0] x, y;
        rand_coords(x, y);
        send(x, y, ($urandom_range(0, 7) != 0), 16'($urandom), 3'($urandom),
             ($urandom_range(0, 7) != 0));
    endtask

    task automatic read_px(input int a, output logic [15:0] d);
        scan_rd_en   = 1'b1;
        scan_rd_addr = AW'(a);
        @(posedge clk);
        #1;
        scan_rd_en = 1'b0;
        d = scan_rd_data;
    endtask

    task automatic sweep(input string tag);
        logic [15:0] d;
        int          bad = 0;
        int          first = -1;
        for (int i = 0; i < SIZE; i++) begin
            read_px(i, d);
            if (d !== mem_m[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check(tag, bad, 0);
        if (bad != 0) $display("  first differing address %0d", first);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_written"}, pix_written, wr_m);
        check({tag, "_dropped"}, pix_dropped, dr_m);
    endtask

    // Clear while the upstream keeps offering fragments; a second request mid-clear must be ignored.
    task automatic do_clear(input logic [15:0] col);
        logic [15:0] x, y;
        int          low = 0;
        fb_clear       = 1'b1;
        fb_clear_color = col;
        drive_frag(16'($urandom_range(0, W - 1)), 16'($urandom_range(0, H - 1)), 1'b1,
                   16'($urandom), 3'b111, 1'b1);
        @(posedge clk);
        #1;
        fb_clear = 1'b0;
        check("clear_busy", fb_clearing, 1'b1);
        while (fif.frag_in_ready == 1'b0 && low < SIZE + 20) begin
            low++;
            rand_coords(x, y);
            fif.frag_in.x     = x;
            fif.frag_in.y     = y;
            fif.frag_in.valid = 1'b1;
            fif.color_in      = rgb565_t'(16'($urandom));
            fif.frag_in_valid = 1'b1;
            if (low == 50) begin
                fb_clear       = 1'b1;
                fb_clear_color = ~col;
            end else begin
                fb_clear = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        fif.frag_in_valid = 1'b0;
        fb_clear          = 1'b0;
        check("clear_ready_low_cycles", low, SIZE + 1);
        check("clear_done_flag", fb_clearing, 1'b0);
        for (int i = 0; i < SIZE; i++) mem_m[i] = col;
        wr_m = 0;
        dr_m = 0;
        check_counters("clear");
    endtask

    initial begin
        logic [15:0] d;
        fif.frag_in       = '0;
        fif.color_in      = '0;
        fif.frag_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", fif.frag_in_ready, 1'b1);
        check("reset_clearing", fb_clearing, 1'b0);
        check("reset_scan", scan_rd_data, 16'h0000);
        check("reset_written", pix_written, 0);
        check("reset_dropped", pix_dropped, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_clear(16'h0000);
        sweep("init_clear_sweep");

        send(16'd16, 16'd0, 1'b1, 16'hFFFF, 3'b111, 1'b1);
        send(16'd0, 16'd8, 1'b1, 16'hFFFF, 3'b111, 1'b1);
        send(16'd1, 16'd1, 1'b0, 16'hFFFF, 3'b111, 1'b1);
        send(16'd2, 16'd2, 1'b1, 16'hFFFF, 3'b111, 1'b0);
        idle(1);
        check("drop_count", pix_dropped, 32'd4);
        check("drop_written", pix_written, 32'd0);
        sweep("drop_sweep");

        send(16'd3, 16'd2, 1'b1, 16'hF800, 3'b111, 1'b1);
        idle(1);
        read_px(3 + 2 * W, d);
        check("single_write", d, 16'hF800);
        check("single_written", pix_written, 32'd1);

        send(16'd5, 16'd1, 1'b1, 16'h07E0, 3'b111, 1'b1);
        idle(1);
        send(16'd5, 16'd1, 1'b1, 16'hFFFF, 3'b001, 1'b1);
        idle(1);
        read_px(5 + 1 * W, d);
        check("masked_rmw", d, 16'h07FF);

        send(16'd7, 16'd3, 1'b1, 16'hF800, 3'b100, 1'b1);
        send(16'd7, 16'd3, 1'b1, 16'h001F, 3'b001, 1'b1);
        idle(1);
        read_px(7 + 3 * W, d);
        check("b2b_forward", d, 16'hF81F);
        check_counters("directed");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            else rand_send();
        end
        idle(1);
        check_counters("random");
        sweep("random_sweep");

        do_clear(16'h1234);
        sweep("clear_sweep");

        for (int i = 0; i < 200; i++) rand_send();
        idle(1);
        check_counters("random2");

        fb_clear       = 1'b1;
        fb_clear_color = 16'h5A5A;
        @(posedge clk);
        #1;
        fb_clear = 1'b0;
        repeat (101) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", fif.frag_in_ready, 1'b1);
        check("rst_mid_clearing", fb_clearing, 1'b0);
        check("rst_mid_scan", scan_rd_data, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) mem_m[i] = 16'h5A5A;
        wr_m = 0;
        dr_m = 0;
        check_counters("rst_mid");
        sweep("rst_mid_sweep");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
